// File: rtl/fpu_div_iter.sv
// Iterative IEEE-754 single divider (restoring radix-2, one quotient bit per cycle); FPU_DIV_ABORT_EN selects restart-on-Start.
// Latency: Done 30 cycles after an accepted Start, 2 cycles for NaN/inf/zero operands.
// Backpressure: Start is ignored while Busy, unless FPU_DIV_ABORT_EN is defined, in which case it restarts the divide.
module fpu_div_iter #(
    parameter int QBITS = 26
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] FPU_Output,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow
);

    localparam int CW = $clog2(QBITS);

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIVIDE, S_NORM, S_ROUND, S_DONE} state_t;

    state_t             state, state_nxt;
    logic               accept;
    logic [31:0]        a_q, b_q;
    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [24:0]        rem_q;
    logic [23:0]        div_q;
    logic [QBITS-1:0]   quo_q;
    logic [CW-1:0]      cnt_q;
    logic               sticky_q;

`ifdef FPU_DIV_ABORT_EN
    assign accept = Start;
`else
    assign accept = Start && (state == S_IDLE);
`endif

    // Operand classification; denormals count as zero
    logic [7:0] a_exp, b_exp;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_w;
    assign a_exp  = a_q[30:23];
    assign b_exp  = b_q[30:23];
    assign a_zero = (a_exp == 8'h00);
    assign b_zero = (b_exp == 8'h00);
    assign a_inf  = (a_exp == 8'hFF) && (a_q[22:0] == 23'd0);
    assign b_inf  = (b_exp == 8'hFF) && (b_q[22:0] == 23'd0);
    assign a_nan  = (a_exp == 8'hFF) && (a_q[22:0] != 23'd0);
    assign b_nan  = (b_exp == 8'hFF) && (b_q[22:0] != 23'd0);
    assign sign_w = a_q[31] ^ b_q[31];

    // Special-operand result, resolved without running the iteration
    logic        special, spec_exc;
    logic [31:0] spec_res;
    always_comb begin
        special  = 1'b1;
        spec_exc = 1'b0;
        spec_res = 32'd0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res = 32'h7FC00000;
            spec_exc = 1'b1;
        end else if (a_inf) begin
            spec_res = {sign_w, 8'hFF, 23'd0};
        end else if (b_zero) begin
            spec_res = {sign_w, 8'hFF, 23'd0};
            spec_exc = 1'b1;
        end else if (b_inf || a_zero) begin
            spec_res = {sign_w, 31'd0};
        end else begin
            special = 1'b0;
        end
    end

    // One restoring step: subtract when the remainder covers the divisor
    logic        q_bit;
    logic [24:0] rem_sub;
    assign q_bit   = (rem_q >= {1'b0, div_q});
    assign rem_sub = rem_q - {1'b0, div_q};

    // Round-to-nearest-even on the normalised quotient, then range check
    logic [24:0]       mant_sum;
    logic              round_up, ovf_w, unf_w;
    logic signed [9:0] exp_rnd;
    logic [22:0]       frac_rnd;
    logic [31:0]       rnd_res;
    always_comb begin
        round_up = quo_q[1] & (sticky_q | quo_q[2]);
        mant_sum = {1'b0, quo_q[QBITS-1:2]} + {24'd0, round_up};
        exp_rnd  = mant_sum[24] ? (exp_q + 10'sd1) : exp_q;
        frac_rnd = mant_sum[24] ? mant_sum[23:1] : mant_sum[22:0];
        ovf_w    = (exp_rnd >= 10'sd255);
        unf_w    = (exp_rnd <= 10'sd0);
        if (ovf_w)
            rnd_res = {sign_q, 8'hFF, 23'd0};
        else if (unf_w)
            rnd_res = {sign_q, 31'd0};
        else
            rnd_res = {sign_q, exp_rnd[7:0], frac_rnd};
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt = state;
        Busy      = (state != S_IDLE);
        Done      = (state == S_DONE);
        case (state)
            S_IDLE:   state_nxt = S_IDLE;
            S_UNPACK: state_nxt = special ? S_DONE : S_DIVIDE;
            S_DIVIDE: if (cnt_q == CW'(QBITS - 1)) state_nxt = S_NORM;
            S_NORM:   state_nxt = S_ROUND;
            S_ROUND:  state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (accept)
            state_nxt = S_UNPACK;
    end

    // Datapath and result registers; results only land on entry to DONE
    always_ff @(posedge Clk) begin
        if (Rst) begin
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            sign_q     <= 1'b0;
            exp_q      <= 10'sd0;
            rem_q      <= 25'd0;
            div_q      <= 24'd0;
            quo_q      <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            FPU_Output <= 32'd0;
            Exception  <= 1'b0;
            Overflow   <= 1'b0;
            Underflow  <= 1'b0;
        end else begin
            if (accept) begin
                a_q <= a_operand;
                b_q <= b_operand;
            end
            case (state)
                S_UNPACK: begin
                    sign_q <= sign_w;
                    exp_q  <= $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + 10'sd127;
                    rem_q  <= {2'b01, a_q[22:0]};
                    div_q  <= {1'b1, b_q[22:0]};
                    quo_q  <= '0;
                    cnt_q  <= '0;
                    if (state_nxt == S_DONE) begin
                        FPU_Output <= spec_res;
                        Exception  <= spec_exc;
                        Overflow   <= 1'b0;
                        Underflow  <= 1'b0;
                    end
                end
                S_DIVIDE: begin
                    rem_q <= (q_bit ? rem_sub : rem_q) << 1;
                    quo_q <= {quo_q[QBITS-2:0], q_bit};
                    cnt_q <= cnt_q + CW'(1);
                end
                S_NORM: begin
                    sticky_q <= (rem_q != 25'd0) | (quo_q[QBITS-1] & quo_q[0]);
                    if (!quo_q[QBITS-1]) begin
                        quo_q <= quo_q << 1;
                        exp_q <= exp_q - 10'sd1;
                    end
                end
                S_ROUND: begin
                    if (state_nxt == S_DONE) begin
                        FPU_Output <= rnd_res;
                        Exception  <= 1'b0;
                        Overflow   <= ovf_w;
                        Underflow  <= unf_w;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
